// File: rtl/eth_stats_axi_reader.sv
// AXI4-Lite master that optionally pops the stats collector FIFO, reads the 14
// stats words one at a time and presents them as a single 448-bit snapshot.
module eth_stats_axi_reader #(
  parameter logic [11:0] base_addr = 12'h000,
  parameter int unsigned timeout   = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         pop_fifo,
  output logic         busy,
  output logic         error,
  output logic [1:0]   err_code,
  output logic         snap_valid,
  input  logic         snap_ready,
  output logic [447:0] snap_data,
  output logic [11:0]  m_axi_awaddr,
  output logic [2:0]   m_axi_awprot,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [31:0]  m_axi_wdata,
  output logic [3:0]   m_axi_wstrb,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic [11:0]  m_axi_araddr,
  output logic [2:0]   m_axi_arprot,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [31:0]  m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready
);

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 14;
  localparam int unsigned N_FLDS  = 7;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned WD_W    = (timeout > 1) ? $clog2(timeout) : 1;

  localparam logic [ADDR_W-1:0] POP_ADDR   = base_addr + 12'h040;
  localparam logic [ADDR_W-1:0] STATS_ADDR = base_addr + 12'h010;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_POP_AW, S_POP_B, S_RD_AR, S_RD_R, S_OUT
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [WD_W-1:0]                 wd_q, wd_d;
  logic                            armed_q, armed_d;
  logic                            busy_q, busy_d;
  logic                            error_q, error_d;
  logic [1:0]                      err_code_q, err_code_d;
  logic                            snap_valid_q, snap_valid_d;
  logic [447:0]                    snap_data_q, snap_data_d;
  logic [N_WORDS-1:0][WORD_W-1:0]  shadow_q, shadow_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [ADDR_W-1:0]               araddr_q, araddr_d;

  logic                            wd_expired;
  logic                            abort;
  logic [1:0]                      abort_code;
  logic                            load_snap;
  logic [N_FLDS-1:0][63:0]         snap_pack;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    armed_d      = 1'b1;
    busy_d       = busy_q;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    shadow_d     = shadow_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    abort        = 1'b0;
    abort_code   = ERR_NONE;
    load_snap    = 1'b0;
    snap_pack    = '0;
    wd_expired   = (timeout != 0) && (wd_q == WD_W'(timeout - 1));

    unique case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          busy_d     = 1'b1;
          err_code_d = ERR_NONE;
          idx_d      = '0;
          if (pop_fifo) begin
            state_d   = S_POP_AW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_POP_AW: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_POP_B;
          bready_d = 1'b1;
        end else if (wd_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      S_POP_B: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp == RESP_OKAY) begin
            state_d   = S_RD_AR;
            arvalid_d = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_BRESP;
          end
        end else if (wd_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      S_RD_AR: begin
        if (m_axi_arready) begin
          state_d   = S_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (wd_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      S_RD_R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp == RESP_OKAY) begin
            shadow_d[idx_q] = m_axi_rdata;
            if (idx_q == IDX_W'(N_WORDS - 1)) begin
              state_d      = S_OUT;
              snap_valid_d = 1'b1;
              load_snap    = 1'b1;
            end else begin
              idx_d     = idx_q + IDX_W'(1);
              state_d   = S_RD_AR;
              arvalid_d = 1'b1;
            end
          end else begin
            abort      = 1'b1;
            abort_code = ERR_RRESP;
          end
        end else if (wd_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      S_OUT: begin
        if (snap_ready) begin
          snap_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word 2k is the low half of field k; field 0 (time) sits at the MSB end
    for (int k = 0; k < N_FLDS; k++) begin
      snap_pack[N_FLDS-1-k] = {shadow_d[2*k+1], shadow_d[2*k]};
    end
    if (load_snap) snap_data_d = snap_pack;

    if (abort) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = abort_code;
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      bready_d   = 1'b0;
      arvalid_d  = 1'b0;
      rready_d   = 1'b0;
    end

    araddr_d = STATS_ADDR + ADDR_W'({idx_d, 2'b00});
    wd_d     = (state_d != state_q) ? '0 : wd_q + WD_W'(1);
  end

  // armed_q blocks a start that coincides with the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wd_q         <= '0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
      shadow_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= STATS_ADDR;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
      shadow_q     <= shadow_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      araddr_q     <= araddr_d;
    end
  end

  assign busy          = busy_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign snap_valid    = snap_valid_q;
  assign snap_data     = snap_data_q;
  assign m_axi_awaddr  = POP_ADDR;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = 32'd0;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
